// File: rtl/membus_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and starvation limit default.
package membus_arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DACK = 1'b1
    } state_e;

    // Counter width able to hold 0..limit; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/membus_arb_if.sv
// Bundle of pipeline, debug and shared-memory signals around the data-memory arbiter.
interface membus_arb_if;

    logic        mwmem;
    logic        mrmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [31:0] mmo;
    logic        stall;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] ddata;
    logic        dack;
    logic [31:0] dq;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    // Requester/memory side: pipeline, debug port and the data memory itself.
    modport master (
        output mwmem, mrmem, malu, mb, dreq, dwe, daddr, ddata, mem_dout,
        input  mmo, stall, dack, dq, mem_addr, mem_din, mem_we
    );

    // Arbiter side.
    modport slave (
        input  mwmem, mrmem, malu, mb, dreq, dwe, daddr, ddata, mem_dout,
        output mmo, stall, dack, dq, mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/membus_starve_cnt.sv
// Saturating counter of consecutive debug denials; clear has priority over increment.
module membus_starve_cnt #(
    parameter int unsigned Limit = 4,
    parameter int unsigned Width = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LimitW)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == LimitW);

endmodule

// File: rtl/membus_arb.sv
// Arbitrates the single data-memory port between the pipeline MEM stage and a debug/loader
// requester; the pipeline wins unless the debug side has been denied STARVE_LIMIT times in a row.
module membus_arb
    import membus_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input logic         clock,
    input logic         clrn,
    membus_arb_if.slave bus
);

    localparam int unsigned CntW = cnt_width(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] dq_q, dq_d;
    logic        pipe_acc;
    logic        dgrant;
    logic        starve_sat;
    logic        cnt_inc;
    logic        cnt_clr;

    assign pipe_acc = bus.mwmem | bus.mrmem;

    always_comb begin
        state_d      = state_q;
        dgrant       = 1'b0;
        bus.dack     = 1'b0;
        bus.stall    = 1'b0;
        bus.mem_addr = bus.malu;
        bus.mem_din  = bus.mb;
        bus.mem_we   = bus.mwmem;
        case (state_q)
            ST_IDLE: begin
                dgrant = bus.dreq & (~pipe_acc | starve_sat);
                if (dgrant) begin
                    state_d = ST_DACK;
                end
            end
            ST_DACK: begin
                // Any dreq still high here belongs to the request just completed.
                bus.dack = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A granted debug access replaces the pipeline's store, so the store is never lost
        // silently: stall forces the MEM stage to repeat it next cycle.
        if (dgrant) begin
            bus.mem_addr = bus.daddr;
            bus.mem_din  = bus.ddata;
            bus.mem_we   = bus.dwe;
            bus.stall    = pipe_acc;
        end
    end

    assign dq_d    = (dgrant && !bus.dwe) ? bus.mem_dout : dq_q;
    assign cnt_inc = (state_q == ST_IDLE) & bus.dreq & ~dgrant;
    assign cnt_clr = dgrant | ~bus.dreq;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            dq_q    <= '0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
        end
    end

    membus_starve_cnt #(
        .Limit (STARVE_LIMIT),
        .Width (CntW)
    ) u_starve_cnt (
        .clk_i  (clock),
        .rst_ni (clrn),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .sat_o  (starve_sat)
    );

    assign bus.dq  = dq_q;
    assign bus.mmo = bus.mem_dout;

endmodule
